// File: rtl/viterbi_pkg.sv
// Shared Viterbi encoder/decoder definitions: code parameters, FSM states,
// and the code-pair function that the encoder and decoder models share.
package viterbi_pkg;

  localparam int K       = 7;
  localparam int STATE_W = K - 1;

  // Bit K-1 taps the current input, bit 0 taps the oldest state bit.
  localparam logic [K-1:0] G0_DEF = 7'o171;
  localparam logic [K-1:0] G1_DEF = 7'o133;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_e;

  // Code pair {c0,c1} for window w = {b, sr}.
  function automatic logic [1:0] conv_pair(input logic [K-1:0] w,
                                           input logic [K-1:0] g0,
                                           input logic [K-1:0] g1);
    return {^(w & g0), ^(w & g1)};
  endfunction

endpackage

// File: rtl/conv_enc_k7.sv
// Rate-1/2 K=7 feedforward convolutional encoder with a single output
// register and valid/ready handshakes on both sides.
// Optional zero-tail termination: define CONV_ENC_TAIL_EN.
module conv_enc_k7
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_bit,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [1:0]         out_pair,
  output logic               out_tail,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] enc_state,
  output logic               busy
);

  fsm_e               state_q, state_d;
  logic [STATE_W-1:0] sr_q, sr_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_pair_q, out_pair_d;
`ifdef CONV_ENC_TAIL_EN
  logic [2:0]         tail_cnt_q, tail_cnt_d;
  logic               out_tail_q, out_tail_d;
`endif

  logic       adv, xfer, tail_step, enc, b;
  logic [1:0] pair;

  // The output register may load when empty or being drained this cycle.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && (state_q == IDLE || state_q == DATA);
  assign xfer     = in_valid && in_ready;
`ifdef CONV_ENC_TAIL_EN
  assign tail_step = adv && (state_q == TAIL);
`else
  assign tail_step = 1'b0;
`endif
  assign enc  = xfer || tail_step;
  assign b    = xfer && in_bit;   // flush bits encode as zero
  assign pair = conv_pair({b, sr_q}, G0, G1);

  // Next-state: shift register, output register and frame FSM.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    out_valid_d = out_valid_q;
    out_pair_d  = out_pair_q;
`ifdef CONV_ENC_TAIL_EN
    tail_cnt_d  = tail_cnt_q;
    out_tail_d  = out_tail_q;
`endif
    if (adv) out_valid_d = enc;
    if (enc) begin
      out_pair_d = pair;
      sr_d       = {b, sr_q[STATE_W-1:1]};
`ifdef CONV_ENC_TAIL_EN
      out_tail_d = tail_step;
`endif
    end
    case (state_q)
      IDLE, DATA: begin
        if (xfer) begin
          if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
            state_d    = TAIL;
            tail_cnt_d = 3'd0;
`else
            // No flush: restart the next frame from state 0 directly.
            state_d = IDLE;
            sr_d    = '0;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL: begin
        if (tail_step) begin
          tail_cnt_d = tail_cnt_q + 3'd1;
          // Six zero bits have flushed sr back to state 0.
          if (tail_cnt_q == 3'd5) state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= 2'b00;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt_q  <= 3'd0;
      out_tail_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_pair_q  <= out_pair_d;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt_q  <= tail_cnt_d;
      out_tail_q  <= out_tail_d;
`endif
    end
  end

  assign out_pair  = out_pair_q;
  assign out_valid = out_valid_q;
`ifdef CONV_ENC_TAIL_EN
  assign out_tail  = out_tail_q;
`else
  assign out_tail  = 1'b0;
`endif
  assign enc_state = sr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_enc_k7.sv
// Bench for conv_enc_k7: directed frames plus random frames, scored against
// a delay-line convolution model of the code.
`timescale 1ns/1ps
module tb_conv_enc_k7;

  logic       clk = 1'b0, rst = 1'b1;
  logic       in_bit = 1'b0, in_last = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_tail, out_valid, busy;
  logic [1:0] out_pair;
  logic [5:0] enc_state;

`ifdef CONV_ENC_TAIL_EN
  localparam int TAILN = 6;
`else
  localparam int TAILN = 0;
`endif
  localparam logic [6:0] TG0 = 7'o171;
  localparam logic [6:0] TG1 = 7'o133;

  always #5 clk = ~clk;

  conv_enc_k7 dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_pair(out_pair),
    .out_tail(out_tail), .out_valid(out_valid), .out_ready(out_ready),
    .enc_state(enc_state), .busy(busy)
  );

  typedef struct { logic [1:0] pair; logic tail; } exp_t;

  int         vectors = 0, errs = 0;
  exp_t       sb[$];
  logic [2:0] obs_log[$];
  bit         hist[$];
  logic [5:0] exp_state = '0;
  bit         watch_gap = 0, rnd_stall = 0;
  int         gap_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: each code bit is the XOR of the generator-weighted input history.
  task automatic model_bit(input bit bv, input bit tl);
    bit   c0 = 0, c1 = 0, v;
    exp_t e;
    for (int j = 0; j < 7; j++) begin
      if (j == 0) v = bv;
      else v = (hist.size() >= j) ? hist[hist.size()-j] : 1'b0;
      c0 ^= TG0[6-j] & v;
      c1 ^= TG1[6-j] & v;
    end
    e.pair = {c0, c1};
    e.tail = tl;
    sb.push_back(e);
    hist.push_back(bv);
  endtask

  function automatic logic [5:0] state_of();
    logic [5:0] s = '0;
    for (int j = 0; j < 6; j++)
      if (hist.size() > j) s[5-j] = hist[hist.size()-1-j];
    return s;
  endfunction

  task automatic model_push(input bit bv, input bit last);
    model_bit(bv, 1'b0);
    exp_state = state_of();
    if (last) begin
      repeat (TAILN) model_bit(1'b0, 1'b1);
      if (TAILN == 0) exp_state = '0;
      hist.delete();
    end
  endtask

  // Output monitor: scoreboard, hold-under-stall and stall in_ready checks.
  logic [1:0] held_pair;
  logic       held_tail;
  bit         held_v = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v <= 0;
    end else begin
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_pair", out_pair, held_pair);
        chk("hold_tail", out_tail, held_tail);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_pair_count", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pair", out_pair, e.pair);
          chk("tail", out_tail, e.tail);
        end
        obs_log.push_back({out_tail, out_pair});
      end
      if (watch_gap && sb.size() > 0 && !out_valid) gap_cnt++;
      held_v    <= out_valid && !out_ready;
      held_pair <= out_pair;
      held_tail <= out_tail;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int k, input int ss, input int sl);
    if (rnd_stall) out_ready = ($urandom_range(0, 3) != 0);
    else           out_ready = !(k >= ss && k < ss + sl);
  endtask

  // Present a frame bit-by-bit; out_ready low for frame cycles [ss, ss+sl).
  task automatic send_frame(input logic [63:0] bits, input int n, input int ss, input int sl);
    int i = 0, k = 0;
    bit acc;
    while (i < n) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      in_last  = (i == n - 1);
      set_ready(k, ss, sl);
      @(negedge clk);
      acc = in_ready;
      if (acc) model_push(bits[i], i == n - 1);
      tick();
      if (acc) begin
        i++;
        chk("latency_valid", out_valid, 1);
        chk("enc_state", enc_state, exp_state);
      end
      k++;
      if (k > 500) begin
        chk("send_timeout_bits_left", n - i, 0);
        break;
      end
    end
    in_valid = 1'b0;
    in_bit   = 1'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Run until every expected pair has left the output register.
  task automatic drain(input int ss, input int sl);
    int k = 0;
    while ((sb.size() > 0 || out_valid) && k < 300) begin
      set_ready(k, ss, sl);
      tick();
      k++;
    end
    if (k >= 300) chk("drain_timeout_pending", sb.size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic check_impulse(input string tag);
    logic [1:0] ip[7];
    ip = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    chk({tag, "_len"}, obs_log.size(), 1 + TAILN);
    for (int i = 0; i < obs_log.size() && i < 7; i++) begin
      chk({tag, "_pair"}, obs_log[i][1:0], ip[i]);
      chk({tag, "_tail"}, obs_log[i][2], (i > 0));
    end
    chk({tag, "_end_state"}, enc_state, 0);
  endtask

  initial begin
    logic [63:0] a, bb;
    int n, tails;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pair", out_pair, 0);
    chk("rst_out_tail", out_tail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enc_state", enc_state, 0);
    rst = 1'b0;
    tick();

    // Impulse
    obs_log.delete();
    send_frame(64'd1, 1, 100, 0);
    drain(100, 0);
    check_impulse("impulse");

    // All-zero 8-bit frame
    obs_log.delete();
    send_frame(64'd0, 8, 100, 0);
    drain(100, 0);
    chk("zero_len", obs_log.size(), 8 + TAILN);
    tails = 0;
    foreach (obs_log[i]) begin
      chk("zero_pair", obs_log[i][1:0], 0);
      chk("zero_tail", obs_log[i][2], (i >= 8));
    end
    chk("zero_busy", busy, 0);

    // Backpressure mid-data and mid-tail
    obs_log.delete();
    a = {32'd0, $urandom};
    send_frame(a, 16, 5, 3);
    drain(2, 2);
    chk("bp_len", obs_log.size(), 16 + TAILN);
    chk("bp_busy", busy, 0);
    chk("bp_end_state", enc_state, 0);

    // Back-to-back frames
    obs_log.delete();
    a  = {32'd0, $urandom};
    bb = {32'd0, $urandom};
    send_frame(a, 4, 100, 0);
    gap_cnt = 0;
    watch_gap = 1;
    send_frame(bb, 4, 100, 0);
    drain(100, 0);
    watch_gap = 0;
    chk("b2b_gap_cycles", gap_cnt, 0);
    chk("b2b_len", obs_log.size(), 2 * (4 + TAILN));

    // Reset after three tail pairs, then a fresh impulse
    send_frame(64'd1, 1, 100, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    sb.delete();
    hist.delete();
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_enc_state", enc_state, 0);
    chk("midrst_busy", busy, 0);
    obs_log.delete();
    send_frame(64'd1, 1, 100, 0);
    drain(100, 0);
    check_impulse("post_rst_impulse");

    // Random frames under random backpressure
    rnd_stall = 1;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 20);
      a = {$urandom, $urandom};
      send_frame(a, n, 0, 0);
      if (f % 2 == 1) drain(0, 0);
    end
    drain(0, 0);
    rnd_stall = 0;
    chk("rnd_busy", busy, 0);
    chk("rnd_end_state", enc_state, 0);

`ifndef CONV_ENC_TAIL_EN
    // Two single-bit frames without flush
    obs_log.delete();
    send_frame(64'd1, 1, 100, 0);
    send_frame(64'd1, 1, 100, 0);
    drain(100, 0);
    chk("notail_len", obs_log.size(), 2);
    foreach (obs_log[i]) chk("notail_pair", obs_log[i], 3'b011);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
